// File: rtl/dm_arb.sv
// Two-requester arbiter in front of a single-ported data memory: round-robin
// between CPU (0) and loader (1), with a bounded lock burst for the loader.
module dm_arb #(
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic        dbg_locked,
    output logic [7:0]  dbg_bcnt,
    output logic        dbg_last
);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    localparam logic [7:0] BMAX = 8'(BURST_MAX);

    lock_state_e state_q, state_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic        last_q;
    logic        burst_hold;
    logic        burst_done;

    // Handshake: a request is accepted in exactly the cycle its gnt is high;
    // the requester keeps req and its op fields stable until then.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        burst_hold = (state_q == LOCKED) && req1 && lock1 && (bcnt_q < BMAX);
        burst_done = (state_q == LOCKED) && (bcnt_q == BMAX);
        if (burst_hold) begin
            gnt1 = 1'b1;
        end else if (burst_done && req0) begin
            gnt0 = 1'b1;
        end else if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            UNLOCKED: begin
                if (gnt1 && lock1) begin
                    state_d = LOCKED;
                    bcnt_d  = 8'd1;
                end
            end
            LOCKED: begin
                if (!lock1 || !req1 || (bcnt_q == BMAX)) begin
                    state_d = UNLOCKED;
                    bcnt_d  = 8'd0;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = UNLOCKED;
                bcnt_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
            bcnt_q  <= 8'd0;
            last_q  <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            if (gnt0 || gnt1) begin
                last_q <= gnt1;
            end
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    always_comb begin
        mem_re    = (gnt0 & ~we0) | (gnt1 & ~we1);
        mem_we    = (gnt0 & we0) | (gnt1 & we1);
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign rdata      = mem_rdata;
    assign dbg_locked = (state_q == LOCKED);
    assign dbg_bcnt   = bcnt_q;
    assign dbg_last   = last_q;

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb: round-robin, write/read-back, lock bursts,
// mid-burst reset, plus per-cycle exclusivity checks.
module tb_dm_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1, lock1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic        dbg_locked, dbg_last;
    logic [7:0]  dbg_bcnt;

    int n_cmp = 0;
    int n_err = 0;
    bit run_inv = 1'b0;

    logic [15:0] mem [0:255];

    dm_arb #(.BURST_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .dbg_locked(dbg_locked), .dbg_bcnt(dbg_bcnt), .dbg_last(dbg_last)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One arbitration cycle: inputs already driven; check at negedge, then step.
    task automatic cyc(input string tag, input logic eg0, input logic eg1,
                       input logic erv0, input logic erv1, input logic [15:0] ea);
        @(negedge clk);
        check({tag, ".gnt0"}, gnt0, eg0);
        check({tag, ".gnt1"}, gnt1, eg1);
        check({tag, ".rvalid0"}, rvalid0, erv0);
        check({tag, ".rvalid1"}, rvalid1, erv1);
        check({tag, ".mem_addr"}, mem_addr, ea);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (run_inv && rst_n) begin
            check("inv_gnt_excl", gnt0 & gnt1, 1'b0);
            check("inv_mem_excl", mem_re & mem_we, 1'b0);
            check("inv_gnt_req", (gnt0 & ~req0) | (gnt1 & ~req1), 1'b0);
            check("inv_re_map", mem_re, (gnt0 & ~we0) | (gnt1 & ~we1));
            check("inv_we_map", mem_we, (gnt0 & we0) | (gnt1 & we1));
        end
    end

    initial begin
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; lock1 = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst.last", dbg_last, 1'b1);
        check("rst.locked", dbg_locked, 1'b0);
        check("rst.bcnt", dbg_bcnt, 8'd0);
        check("rst.rvalid0", rvalid0, 1'b0);
        check("rst.rvalid1", rvalid1, 1'b0);
        rst_n = 1'b1;
        run_inv = 1'b1;
        #1;

        // Both read: alternate starting with requester 0.
        req0 = 1; we0 = 0; addr0 = 16'h0100;
        req1 = 1; we1 = 0; addr1 = 16'h0200;
        cyc("rr_a", 1, 0, 0, 0, 16'h0100);
        cyc("rr_b", 0, 1, 1, 0, 16'h0200);
        cyc("rr_c", 1, 0, 0, 1, 16'h0100);
        cyc("rr_d", 0, 1, 1, 0, 16'h0200);
        req0 = 0; req1 = 0;
        cyc("rr_e", 0, 0, 0, 1, 16'h0000);
        #2;
        check("idle.wdata", mem_wdata, 16'h0000);
        cyc("rr_f", 0, 0, 0, 0, 16'h0000);

        // Loader write, CPU read-back.
        req1 = 1; we1 = 1; addr1 = 16'h0010; wdata1 = 16'hBEEF;
        #2;
        check("wr.mem_we", mem_we, 1'b1);
        check("wr.mem_re", mem_re, 1'b0);
        check("wr.wdata", mem_wdata, 16'hBEEF);
        cyc("wr", 0, 1, 0, 0, 16'h0010);
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        #2;
        check("rd.mem_re", mem_re, 1'b1);
        cyc("rd", 1, 0, 0, 0, 16'h0010);
        req0 = 0;
        #2;
        check("rd.rdata", rdata, 16'hBEEF);
        cyc("rd_ret", 0, 0, 1, 0, 16'h0000);
        cyc("rd_idle", 0, 0, 0, 0, 16'h0000);

        // Full burst: 8 loader grants, one CPU grant, then loader again.
        req0 = 1; we0 = 0; addr0 = 16'h0020;
        req1 = 1; we1 = 0; addr1 = 16'h0030; lock1 = 1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 9) check("burst.bcnt_max", dbg_bcnt, 8'd8);
            cyc($sformatf("burst_%0d", i), i == 9, i != 9,
                i == 10, (i >= 2) && (i <= 9), (i == 9) ? 16'h0020 : 16'h0030);
        end
        check("burst.relock", dbg_locked, 1'b1);
        check("burst.rebcnt", dbg_bcnt, 8'd1);
        req0 = 0; req1 = 0; lock1 = 0;
        cyc("burst_end", 0, 0, 0, 1, 16'h0000);
        check("burst.unlocked", dbg_locked, 1'b0);

        // Lock dropped early: tie then goes to requester 0.
        req1 = 1; we1 = 1; addr1 = 16'h0040; wdata1 = 16'h1234; lock1 = 1;
        we0 = 1; addr0 = 16'h0050; wdata0 = 16'h5678;
        for (int i = 1; i <= 4; i++) cyc($sformatf("lk_%0d", i), 0, 1, 0, 0, 16'h0040);
        check("lk.bcnt", dbg_bcnt, 8'd4);
        lock1 = 0; req0 = 1;
        cyc("lk_drop", 1, 0, 0, 0, 16'h0050);
        check("lk.unlocked", dbg_locked, 1'b0);
        cyc("lk_rr1", 0, 1, 0, 0, 16'h0040);
        cyc("lk_rr2", 1, 0, 0, 0, 16'h0050);

        // Reset during a locked burst with a read in flight.
        req0 = 0; we0 = 0;
        req1 = 1; we1 = 0; addr1 = 16'h0060; lock1 = 1;
        cyc("rs_1", 0, 1, 0, 0, 16'h0060);
        cyc("rs_2", 0, 1, 0, 1, 16'h0060);
        check("rs.inflight", rvalid1, 1'b1);
        check("rs.locked_pre", dbg_locked, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rs.rvalid1", rvalid1, 1'b0);
        check("rs.locked", dbg_locked, 1'b0);
        check("rs.bcnt", dbg_bcnt, 8'd0);
        check("rs.last", dbg_last, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1; addr0 = 16'h0070; lock1 = 0;
        #1;
        check("rs.tie_gnt0", gnt0, 1'b1);
        check("rs.tie_gnt1", gnt1, 1'b0);
        @(posedge clk);
        #1;
        cyc("rs_next", 0, 1, 1, 0, 16'h0060);
        req0 = 0; req1 = 0;
        cyc("rs_end", 0, 0, 0, 1, 16'h0000);

        run_inv = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
